// File: rtl/instr_fetch_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, issues one instruction-memory
// request at a time over req/gnt/rvalid, and presents the fetched word to decode.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] InstD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h0000_0003;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pcf;
    logic [31:0]  w_pcf_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_next;
    logic         r_discard;
    logic         w_discard_next;
    logic [31:0]  r_hold_inst;
    logic [31:0]  w_hold_next;

    logic         r_valid_d;
    logic [31:0]  r_inst_d;
    logic [31:0]  r_pcd;
    logic [31:0]  r_pcplus4_d;

    logic [31:0]  w_target;
    logic         w_d_accept;
    logic         w_load_d;
    logic [31:0]  w_load_inst;

    assign w_target   = PCTargetE & ~32'h0000_0003;
    assign w_d_accept = ~StallD & ~FlushD;

    assign IMemReq  = (r_state == S_REQ);
    assign IMemAddr = (r_state == S_REQ) ? r_pcf : 32'h0000_0000;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next    = r_state;
        w_pcf_next      = r_pcf;
        w_fetch_pc_next = r_fetch_pc;
        w_discard_next  = r_discard;
        w_hold_next     = r_hold_inst;
        w_load_d        = 1'b0;
        w_load_inst     = r_hold_inst;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
                if (PCSrcE) begin
                    w_pcf_next = w_target;
                end
            end

            S_REQ: begin
                if (IMemGnt) begin
                    w_fetch_pc_next = r_pcf;
                    w_state_next    = S_WAIT;
                    // A redirect racing the grant still lets the word arrive; it gets dropped.
                    w_discard_next  = PCSrcE;
                    if (PCSrcE) begin
                        w_pcf_next = w_target;
                    end
                end else if (PCSrcE) begin
                    w_pcf_next = w_target;
                end
            end

            S_WAIT: begin
                if (IMemRValid) begin
                    w_discard_next = 1'b0;
                    if (r_discard || PCSrcE) begin
                        w_state_next = S_REQ;
                        if (PCSrcE) begin
                            w_pcf_next = w_target;
                        end
                    end else begin
                        w_pcf_next = r_pcf + 32'd4;
                        if (w_d_accept) begin
                            w_load_d     = 1'b1;
                            w_load_inst  = IMemRData;
                            w_state_next = S_REQ;
                        end else begin
                            w_hold_next  = IMemRData;
                            w_state_next = S_HOLD;
                        end
                    end
                end else if (PCSrcE) begin
                    w_pcf_next     = w_target;
                    w_discard_next = 1'b1;
                end
            end

            S_HOLD: begin
                // The held word is younger than any redirecting branch, so it is dropped.
                if (PCSrcE) begin
                    w_pcf_next   = w_target;
                    w_state_next = S_REQ;
                end else if (w_d_accept) begin
                    w_load_d     = 1'b1;
                    w_state_next = S_REQ;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pcf       <= RESET_PC_ALIGNED;
            r_fetch_pc  <= RESET_PC_ALIGNED;
            r_discard   <= 1'b0;
            r_hold_inst <= NOP_INST;
        end else begin
            r_state     <= w_state_next;
            r_pcf       <= w_pcf_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_discard   <= w_discard_next;
            r_hold_inst <= w_hold_next;
        end
    end

    // IF/ID register: flush beats stall, stall beats load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_d   <= 1'b0;
            r_inst_d    <= NOP_INST;
            r_pcd       <= 32'h0000_0000;
            r_pcplus4_d <= 32'h0000_0000;
        end else if (FlushD) begin
            r_valid_d <= 1'b0;
            r_inst_d  <= NOP_INST;
        end else if (!StallD) begin
            if (w_load_d) begin
                r_valid_d   <= 1'b1;
                r_inst_d    <= w_load_inst;
                r_pcd       <= r_fetch_pc;
                r_pcplus4_d <= r_fetch_pc + 32'd4;
            end else begin
                r_valid_d <= 1'b0;
                r_inst_d  <= NOP_INST;
            end
        end
    end

    assign ValidD   = r_valid_d;
    assign InstD    = r_inst_d;
    assign PCD      = r_pcd;
    assign PCPlus4D = r_pcplus4_d;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: a directed cycle table, hand-written
// latency/reset sequences, and a randomized run against a PC-stream reference model.
`timescale 1ns/1ps
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemGnt   (IMemGnt),
        .IMemRValid(IMemRValid),
        .IMemRData (IMemRData),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .InstD     (InstD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, and return just after the edge.
    task automatic drive(input logic r, input logic g, input logic v, input logic [31:0] d,
                         input logic s, input logic [31:0] t, input logic st, input logic fl);
        rst        = r;
        IMemGnt    = g;
        IMemRValid = v;
        IMemRData  = d;
        PCSrcE     = s;
        PCTargetE  = t;
        StallD     = st;
        FlushD     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pcd, input logic [31:0] inst,
                             input logic [31:0] p4);
        check({tag, "_req"},   {31'b0, IMemReq}, {31'b0, req});
        check({tag, "_addr"},  IMemAddr, addr);
        check({tag, "_valid"}, {31'b0, ValidD}, {31'b0, valid});
        check({tag, "_pcd"},   PCD, pcd);
        check({tag, "_inst"},  InstD, inst);
        check({tag, "_pc4"},   PCPlus4D, p4);
    endtask

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        src;
        logic [31:0] tgt;
        logic        stall;
        logic        flush;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pcd;
        logic [31:0] e_inst;
        logic [31:0] e_p4;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic g, logic v, logic [31:0] d, logic s,
                                logic [31:0] t, logic st, logic fl, logic e_req,
                                logic [31:0] e_addr, logic e_valid, logic [31:0] e_pcd,
                                logic [31:0] e_inst, logic [31:0] e_p4);
        vec_t x;
        x.rst = r; x.gnt = g; x.rv = v; x.rdata = d; x.src = s; x.tgt = t;
        x.stall = st; x.flush = fl; x.e_req = e_req; x.e_addr = e_addr;
        x.e_valid = e_valid; x.e_pcd = e_pcd; x.e_inst = e_inst; x.e_p4 = e_p4;
        return x;
    endfunction

    // Randomized-phase state: memory responder and reference model.
    logic        m_busy;
    int          m_gwait;
    int          m_lat;
    logic [31:0] m_addr;
    logic [31:0] exp_pc;
    logic        md_valid;
    logic [31:0] md_inst;
    logic [31:0] md_pcd;
    logic [31:0] md_p4;
    int          deliveries;
    int          loads;

    initial begin
        rst = 1'b1; IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = 32'h0;
        PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0; FlushD = 1'b0;

        // rst gnt rv rdata  src tgt  stall flush | req addr valid pcd inst p4
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h0,NOP,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h0,NOP,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0,0, 1,32'h0,0,32'h0,NOP,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h0,NOP,32'h0));
        vecs.push_back(mk(0,0,1,32'h13,0,32'h0,0,0, 1,32'h4,1,32'h0,32'h13,32'h4));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h0,NOP,32'h4));
        vecs.push_back(mk(0,0,1,32'h17,0,32'h0,0,0, 1,32'h8,1,32'h4,32'h17,32'h8));
        // stall across the fetch of 0x8: word parks in the hold buffer
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,1,0, 0,32'h0,1,32'h4,32'h17,32'h8));
        vecs.push_back(mk(0,0,1,32'h1b,0,32'h0,1,0, 0,32'h0,1,32'h4,32'h17,32'h8));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,1,0, 0,32'h0,1,32'h4,32'h17,32'h8));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,1,0, 0,32'h0,1,32'h4,32'h17,32'h8));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0,0, 1,32'hC,1,32'h8,32'h1b,32'hC));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h8,NOP,32'hC));
        vecs.push_back(mk(0,0,1,32'h1f,0,32'h0,0,0, 1,32'h10,1,32'hC,32'h1f,32'h10));
        // redirect to 0x100 while waiting on 0x10
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'hC,NOP,32'h10));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h100,0,0, 0,32'h0,0,32'hC,NOP,32'h10));
        vecs.push_back(mk(0,0,1,32'h13,0,32'h0,0,0, 1,32'h100,0,32'hC,NOP,32'h10));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'hC,NOP,32'h10));
        vecs.push_back(mk(0,0,1,32'h113,0,32'h0,0,0, 1,32'h104,1,32'h100,32'h113,32'h104));
        // redirect + flush coincident with rvalid, then an unaligned target
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h100,NOP,32'h104));
        vecs.push_back(mk(0,0,1,32'h117,1,32'h200,0,1, 1,32'h200,0,32'h100,NOP,32'h104));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h100,NOP,32'h104));
        vecs.push_back(mk(0,0,1,32'h213,1,32'h203,0,1, 1,32'h200,0,32'h100,NOP,32'h104));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h100,NOP,32'h104));
        vecs.push_back(mk(0,0,1,32'h213,0,32'h0,0,0, 1,32'h204,1,32'h200,32'h213,32'h204));
        // PC wrap at the top of the address space
        vecs.push_back(mk(0,0,0,32'h0,1,32'hFFFF_FFFC,0,1, 1,32'hFFFF_FFFC,0,32'h200,NOP,32'h204));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'h200,NOP,32'h204));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFF,0,32'h0,0,0, 1,32'h0,1,32'hFFFF_FFFC,32'hFFFF_FFFF,32'h0));
        // redirect while a word sits in the hold buffer
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,1,0, 0,32'h0,1,32'hFFFF_FFFC,32'hFFFF_FFFF,32'h0));
        vecs.push_back(mk(0,0,1,32'h13,0,32'h0,1,0, 0,32'h0,1,32'hFFFF_FFFC,32'hFFFF_FFFF,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h300,1,1, 1,32'h300,0,32'hFFFF_FFFC,NOP,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,0, 0,32'h0,0,32'hFFFF_FFFC,NOP,32'h0));
        vecs.push_back(mk(0,0,1,32'h313,0,32'h0,0,0, 1,32'h304,1,32'h300,32'h313,32'h304));
        // stray rvalid outside WAIT is ignored
        vecs.push_back(mk(0,0,1,32'hDEAD,0,32'h0,0,0, 1,32'h304,0,32'h300,NOP,32'h304));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].src,
                  vecs[i].tgt, vecs[i].stall, vecs[i].flush);
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                      vecs[i].e_pcd, vecs[i].e_inst, vecs[i].e_p4);
        end

        // Variable latency: grant after 3 cycles, data after 5 more.
        loads = 0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
            check("lat_req_hold", {31'b0, IMemReq}, 32'd1);
            check("lat_addr_hold", IMemAddr, 32'h304);
            loads = loads + int'(ValidD);
        end
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        check("lat_req_after_gnt", {31'b0, IMemReq}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
            check("lat_wait_valid", {31'b0, ValidD}, 32'd0);
            loads = loads + int'(ValidD);
        end
        drive(0, 0, 1, 32'h317, 0, 32'h0, 0, 0);
        loads = loads + int'(ValidD);
        check_all("lat_load", 1'b1, 32'h308, 1'b1, 32'h304, 32'h317, 32'h308);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        loads = loads + int'(ValidD);
        check("lat_one_load", loads, 32'd1);

        // Reset while a request is outstanding, then a stray rvalid.
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        check("rst_wait_req", {31'b0, IMemReq}, 32'd0);
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        check_all("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 32'h0);
        drive(0, 0, 1, 32'h31b, 0, 32'h0, 0, 0);
        check_all("rst_stray", 1'b1, 32'h0, 1'b0, 32'h0, NOP, 32'h0);
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        drive(0, 0, 1, 32'h13, 0, 32'h0, 0, 0);
        check_all("rst_refetch", 1'b1, 32'h4, 1'b1, 32'h0, 32'h13, 32'h4);

        // Randomized run: redirects always carry a flush, as from a taken branch.
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        m_busy = 1'b0; m_gwait = int'($urandom_range(0, 3)); m_lat = 0; m_addr = 32'h0;
        exp_pc = 32'h0; md_valid = 1'b0; md_inst = NOP; md_pcd = 32'h0; md_p4 = 32'h0;
        deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        g, v, s, st, req_before;
            logic [31:0] d, t, a_before;
            req_before = IMemReq;
            a_before   = IMemAddr;
            g  = !m_busy && req_before && (m_gwait == 0);
            v  = m_busy && (m_lat == 0);
            d  = v ? (m_addr | 32'h13) : $urandom;
            st = ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                t = 32'hFFFF_FFF0 + {28'h0, 4'($urandom_range(0, 15))};
            else
                t = $urandom & 32'h0000_0FFF;
            drive(0, g, v, d, s, t, st, s);

            if (v) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_lat = m_lat - 1;
            end
            if (g) begin
                m_busy  = 1'b1;
                m_addr  = a_before;
                m_lat   = int'($urandom_range(0, 4));
                m_gwait = int'($urandom_range(0, 3));
            end else if (req_before && m_gwait > 0) begin
                m_gwait = m_gwait - 1;
            end

            if (s) begin
                md_valid = 1'b0;
                md_inst  = NOP;
            end else if (!st) begin
                if (ValidD === 1'b1) begin
                    md_valid   = 1'b1;
                    md_pcd     = exp_pc;
                    md_inst    = exp_pc | 32'h13;
                    md_p4      = exp_pc + 32'd4;
                    exp_pc     = exp_pc + 32'd4;
                    deliveries = deliveries + 1;
                end else begin
                    md_valid = 1'b0;
                    md_inst  = NOP;
                end
            end
            if (s) exp_pc = t & ~32'h3;

            check("rnd_valid", {31'b0, ValidD}, {31'b0, md_valid});
            check("rnd_inst", InstD, md_inst);
            check("rnd_pcd", PCD, md_pcd);
            check("rnd_pc4", PCPlus4D, md_p4);
            if (IMemReq)
                check("rnd_fetch_addr", IMemAddr, exp_pc);
            else
                check("rnd_idle_addr", IMemAddr, 32'h0);
        end
        check("rnd_progress", (deliveries > 50) ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
